// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall interlock.
// The mem_op encoding matches the rest of the core: 3'b000 means no access,
// a set MSB marks a load, and stores use 3'b0xx with a non-zero low field.
package hazard_stall_unit_pkg;

  localparam int REG_W       = 5;
  localparam int MEM_OP_BITS = 3;
  localparam int CNT_W       = 2;

  localparam logic                   LOAD_PRFX = 1'b1;
  localparam logic [MEM_OP_BITS-1:0] MEM_NONE  = 3'b000;
  localparam logic [MEM_OP_BITS-1:0] MEM_SB    = 3'b001;
  localparam logic [MEM_OP_BITS-1:0] MEM_SH    = 3'b010;
  localparam logic [MEM_OP_BITS-1:0] MEM_SW    = 3'b011;
  localparam logic [MEM_OP_BITS-1:0] MEM_LB    = 3'b100;
  localparam logic [MEM_OP_BITS-1:0] MEM_LH    = 3'b101;
  localparam logic [MEM_OP_BITS-1:0] MEM_LW    = 3'b110;
  localparam logic [MEM_OP_BITS-1:0] MEM_LBU   = 3'b111;

  typedef struct packed {
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [REG_W-1:0]       rd;
    logic [MEM_OP_BITS-1:0] mem_op;
  } pipeline_bus_t;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic stall_mem;
    logic bubble_wb;
  } hz_cntrl_bus_t;

  // A load producing a non-x0 register that either ID source reads.
  function automatic logic is_load_use(input logic             op_msb,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs1,
                                       input logic [REG_W-1:0] rs2);
    return (op_msb == LOAD_PRFX) && (rd != '0) && ((rs1 == rd) || (rs2 == rd));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Used for the optional stall performance counters (STALL_PERF_EN).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count up when enabled, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and data-memory-wait interlock beside the forwarding controller.
// Outputs are Mealy so a hazard stalls the pipe in the cycle it is seen.
// cnt_q holds the load-use hold cycles still owed; it survives a memory wait.
// Optional feature macro: STALL_PERF_EN (adds saturating stall-cycle counters).
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 2,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  pipeline_bus_t     id_bus_i,
  input  pipeline_bus_t     ex_bus_i,
  input  pipeline_bus_t     mem_bus_i,
  input  logic              dmem_ready_i,
  input  logic              flush_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o,
  output logic              stall_mem_o,
  output logic              bubble_wb_o,
  output hz_state_t         hz_state_o,
  output logic [PERF_W-1:0] perf_lu_cnt_o,
  output logic [PERF_W-1:0] perf_mem_cnt_o
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALL_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             lu_hit, mem_busy, lu_pending, lu_stall;
  hz_cntrl_bus_t    ctrl;

  // Bus fields this unit does not look at.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{id_bus_i.rd, id_bus_i.mem_op, ex_bus_i.rs1, ex_bus_i.rs2,
                             ex_bus_i.mem_op[MEM_OP_BITS-2:0], mem_bus_i.rs1, mem_bus_i.rs2};

  assign lu_hit = is_load_use(ex_bus_i.mem_op[MEM_OP_BITS-1], ex_bus_i.rd,
                              id_bus_i.rs1, id_bus_i.rs2)
               || is_load_use(mem_bus_i.mem_op[MEM_OP_BITS-1], mem_bus_i.rd,
                              id_bus_i.rs1, id_bus_i.rs2);
  assign mem_busy   = (mem_bus_i.mem_op != MEM_NONE) && !dmem_ready_i;
  // cnt_q is always zero in HZ_IDLE, so this is just lu_hit on a detect cycle.
  assign lu_pending = lu_hit || (cnt_q != '0);
  // A redirect kills the ID instruction, so its hold is dropped, except while
  // memory is frozen (EX re-presents the flush once the wait ends).
  assign lu_stall   = lu_pending && !mem_busy && !(flush_i && (state_q != HZ_MEM_WAIT));
  assign cnt_dec    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

  // State and owed-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a memory wait pre-empts and freezes the load-use count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HZ_IDLE: begin
        if (mem_busy) begin
          state_d = HZ_MEM_WAIT;
        end else if (lu_hit && !flush_i) begin
          state_d = HZ_LU_STALL;
          cnt_d   = LU_RELOAD;
        end
      end
      HZ_LU_STALL: begin
        if (mem_busy) begin
          state_d = HZ_MEM_WAIT;
        end else if (flush_i) begin
          state_d = HZ_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
          if ((cnt_q == '0) && !lu_hit) state_d = HZ_IDLE;
        end
      end
      HZ_MEM_WAIT: begin
        // The release cycle already applies one owed load-use hold.
        if (!mem_busy) begin
          cnt_d   = cnt_dec;
          state_d = lu_pending ? HZ_LU_STALL : HZ_IDLE;
        end
      end
      default: begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall/bubble outputs; memory wait wins, and reset forces everything off.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (mem_busy) begin
        ctrl.stall_if  = 1'b1;
        ctrl.stall_id  = 1'b1;
        ctrl.stall_mem = 1'b1;
        ctrl.bubble_wb = 1'b1;
      end else if (lu_stall) begin
        ctrl.stall_if  = 1'b1;
        ctrl.stall_id  = 1'b1;
        ctrl.bubble_ex = 1'b1;
      end
    end
  end

  assign stall_if_o  = ctrl.stall_if;
  assign stall_id_o  = ctrl.stall_id;
  assign bubble_ex_o = ctrl.bubble_ex;
  assign stall_mem_o = ctrl.stall_mem;
  assign bubble_wb_o = ctrl.bubble_wb;
  assign hz_state_o  = state_q;

`ifdef STALL_PERF_EN
  // Index 0 counts load-use stall cycles, index 1 counts memory-wait cycles.
  logic [1:0]        perf_en;
  logic [PERF_W-1:0] perf_cnt [2];

  assign perf_en = {ctrl.bubble_wb, ctrl.bubble_ex};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    sat_counter #(.W(PERF_W)) u_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (perf_en[gi]),
      .cnt_o (perf_cnt[gi])
    );
  end

  assign perf_lu_cnt_o  = perf_cnt[0];
  assign perf_mem_cnt_o = perf_cnt[1];
`else
  assign perf_lu_cnt_o  = '0;
  assign perf_mem_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (LU_STALL_CYCLES=2).
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11100;  // if, id, bubble_ex
  localparam logic [4:0] C_MW   = 5'b11011;  // if, id, stall_mem, bubble_wb
`ifdef STALL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  pipeline_bus_t id_bus, ex_bus, mem_bus;
  logic          dmem_ready, flush;
  logic          stall_if, stall_id, bubble_ex, stall_mem, bubble_wb;
  hz_state_t     hz_state;
  logic [31:0]   perf_lu, perf_mem;
  logic [4:0]    ctrl_vec;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LU_STALL_CYCLES(2), .PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_bus_i       (id_bus),
    .ex_bus_i       (ex_bus),
    .mem_bus_i      (mem_bus),
    .dmem_ready_i   (dmem_ready),
    .flush_i        (flush),
    .stall_if_o     (stall_if),
    .stall_id_o     (stall_id),
    .bubble_ex_o    (bubble_ex),
    .stall_mem_o    (stall_mem),
    .bubble_wb_o    (bubble_wb),
    .hz_state_o     (hz_state),
    .perf_lu_cnt_o  (perf_lu),
    .perf_mem_cnt_o (perf_mem)
  );

  assign ctrl_vec = {stall_if, stall_id, bubble_ex, stall_mem, bubble_wb};

  function automatic pipeline_bus_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic [2:0] op);
    pipeline_bus_t b;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.mem_op = op;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: check the Mealy outputs and current state, then advance.
  task automatic cyc(input string tag, input logic [4:0] exp_ctrl, input hz_state_t exp_st);
    @(negedge clk);
    chk({tag, ".ctrl"}, 32'(ctrl_vec), 32'(exp_ctrl));
    chk({tag, ".state"}, 32'(hz_state), 32'(exp_st));
    $display("cyc %0d %-10s rst=%b fl=%b rdy=%b ctrl=%b state=%0d", n_cyc, tag, rst, flush,
             dmem_ready, ctrl_vec, hz_state);
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic nop_all();
    id_bus = '0; ex_bus = '0; mem_bus = '0;
    dmem_ready = 1'b1; flush = 1'b0;
  endtask

  initial begin
    // Reset held with a live load-use pattern on the buses.
    rst = 1'b1;
    nop_all();
    ex_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    id_bus = mk(5'd5, 5'd1, 5'd6, MEM_NONE);
    @(posedge clk);
    #1;
    cyc("rst0", C_NONE, HZ_IDLE);
    cyc("rst1", C_NONE, HZ_IDLE);
    chk("rst.perf_lu", perf_lu, 32'd0);
    chk("rst.perf_mem", perf_mem, 32'd0);
    rst = 1'b0;
    nop_all();
    cyc("idle", C_NONE, HZ_IDLE);

    // Load-use: lw x5 then add x6,x5,x1 -> exactly two hold cycles.
    ex_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    id_bus = mk(5'd5, 5'd1, 5'd6, MEM_NONE);
    cyc("lu.det", C_LU, HZ_IDLE);
    ex_bus = '0;
    mem_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    cyc("lu.hold", C_LU, HZ_LU_STALL);
    mem_bus = '0;
    cyc("lu.rel", C_NONE, HZ_LU_STALL);
    id_bus = '0;
    cyc("lu.done", C_NONE, HZ_IDLE);

    // x0 never hazards; independent back-to-back loads; a store is not a load.
    ex_bus  = mk(5'd0, 5'd0, 5'd0, MEM_LW);
    mem_bus = mk(5'd0, 5'd0, 5'd0, MEM_LB);
    id_bus  = mk(5'd0, 5'd0, 5'd3, MEM_NONE);
    cyc("x0", C_NONE, HZ_IDLE);
    ex_bus  = mk(5'd0, 5'd0, 5'd7, MEM_LW);
    mem_bus = mk(5'd0, 5'd0, 5'd8, MEM_LH);
    id_bus  = mk(5'd3, 5'd4, 5'd9, MEM_NONE);
    cyc("ld2ld", C_NONE, HZ_IDLE);
    ex_bus  = mk(5'd5, 5'd2, 5'd5, MEM_SW);
    mem_bus = '0;
    id_bus  = mk(5'd5, 5'd5, 5'd9, MEM_NONE);
    cyc("st_rd", C_NONE, HZ_IDLE);
    nop_all();
    dmem_ready = 1'b0;
    cyc("nomemrdy", C_NONE, HZ_IDLE);

    // Memory wait: sw in MEM, three cycles without acknowledge.
    mem_bus = mk(5'd2, 5'd3, 5'd0, MEM_SW);
    dmem_ready = 1'b0;
    cyc("mw.1", C_MW, HZ_IDLE);
    cyc("mw.2", C_MW, HZ_MEM_WAIT);
    cyc("mw.3", C_MW, HZ_MEM_WAIT);
    dmem_ready = 1'b1;
    cyc("mw.ack", C_NONE, HZ_MEM_WAIT);
    mem_bus = '0;
    cyc("mw.done", C_NONE, HZ_IDLE);

    // Pre-emption: one load-use hold, two wait cycles, then the owed hold.
    ex_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    id_bus = mk(5'd1, 5'd5, 5'd6, MEM_NONE);
    cyc("pe.det", C_LU, HZ_IDLE);
    ex_bus = '0;
    mem_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    dmem_ready = 1'b0;
    cyc("pe.mw1", C_MW, HZ_LU_STALL);
    cyc("pe.mw2", C_MW, HZ_MEM_WAIT);
    dmem_ready = 1'b1;
    cyc("pe.lu", C_LU, HZ_MEM_WAIT);
    mem_bus = '0;
    cyc("pe.rel", C_NONE, HZ_LU_STALL);
    id_bus = '0;
    cyc("pe.done", C_NONE, HZ_IDLE);
    chk("pe.perf_lu", perf_lu, PERF_ON ? 32'd4 : 32'd0);
    chk("pe.perf_mem", perf_mem, PERF_ON ? 32'd5 : 32'd0);

    // Reset in the middle of a load-use stall aborts it at once.
    ex_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    id_bus = mk(5'd5, 5'd1, 5'd6, MEM_NONE);
    cyc("rm.det", C_LU, HZ_IDLE);
    ex_bus = '0;
    mem_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    rst = 1'b1;
    cyc("rm.rst", C_NONE, HZ_LU_STALL);
    rst = 1'b0;
    nop_all();
    cyc("rm.idle", C_NONE, HZ_IDLE);
    chk("rm.perf_lu", perf_lu, 32'd0);

    // Flush in the first LU_STALL cycle drops the hold and returns to idle.
    ex_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    id_bus = mk(5'd5, 5'd1, 5'd6, MEM_NONE);
    cyc("fl.det", C_LU, HZ_IDLE);
    ex_bus = '0;
    mem_bus = mk(5'd0, 5'd0, 5'd5, MEM_LW);
    flush = 1'b1;
    cyc("fl.kill", C_NONE, HZ_LU_STALL);
    nop_all();
    cyc("fl.idle", C_NONE, HZ_IDLE);
    chk("fl.perf_lu", perf_lu, PERF_ON ? 32'd1 : 32'd0);

    // Flush during a memory wait is ignored.
    mem_bus = mk(5'd0, 5'd0, 5'd0, MEM_SB);
    dmem_ready = 1'b0;
    flush = 1'b1;
    cyc("fm.1", C_MW, HZ_IDLE);
    cyc("fm.2", C_MW, HZ_MEM_WAIT);
    dmem_ready = 1'b1;
    flush = 1'b0;
    cyc("fm.ack", C_NONE, HZ_MEM_WAIT);
    nop_all();
    cyc("fm.done", C_NONE, HZ_IDLE);
    chk("fm.perf_mem", perf_mem, PERF_ON ? 32'd2 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
